// File: rtl/bus_transfer_ctrl_if.sv
// Handshake and strobe bundle between the dataBus requesters and bus_transfer_ctrl.
// The master side is the requester pool; the slave side is the arbiter/sequencer.
interface bus_transfer_ctrl_if #(
  parameter int NREG   = 8,
  parameter int NREQ   = 4,
  parameter int REG_AW = 3
);
  logic [NREQ-1:0]        req;
  logic [NREQ*REG_AW-1:0] req_src;
  logic [NREQ*REG_AW-1:0] req_dst;
  logic [NREQ-1:0]        gnt;
  logic                   err;
  logic                   busy;
  logic [NREG-1:0]        reg_oe;
  logic [NREG-1:0]        reg_wr;

  modport master (
    output req, req_src, req_dst,
    input  gnt, err, busy, reg_oe, reg_wr
  );

  modport slave (
    input  req, req_src, req_dst,
    output gnt, err, busy, reg_oe, reg_wr
  );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// Round-robin arbiter/sequencer driving one-hot oe/wr strobes for the shared dataBus.
// Build option TURNAROUND_EN inserts a TURN dead cycle after every DRIVE.
module bus_transfer_ctrl #(
  parameter int NREG   = 8,
  parameter int NREQ   = 4,
  parameter int REG_AW = 3
) (
  input logic                clk,
  input logic                rst_n,
  bus_transfer_ctrl_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [NREG-1:0]   reg_oe_q, reg_oe_d;
  logic [NREG-1:0]   reg_wr_q, reg_wr_d;

  logic [IW-1:0]     arb_ptr;
  logic [IW-1:0]     win;
  logic              found;
  logic              launch;
  logic              bad_idx;
  logic [REG_AW-1:0] win_src;
  logic [REG_AW-1:0] win_dst;

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : IW'(int'(i) + 1);
  endfunction

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i] = (int'(a) == i);
    return v;
  endfunction

  // In DRIVE the just-granted requester already counts as lowest priority,
  // so back-to-back arbitration starts from idx+1 rather than the stale pointer.
  always_comb begin
    arb_ptr = (state_q == DRIVE) ? ptr_after(idx_q) : rr_ptr_q;
    found   = 1'b0;
    win     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(arb_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(arb_ptr) + k) % NREQ);
      end
    end
    win_src = bus.req_src[int'(win)*REG_AW +: REG_AW];
    win_dst = bus.req_dst[int'(win)*REG_AW +: REG_AW];
    bad_idx = (int'(win_src) >= NREG) || (int'(win_dst) >= NREG);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    gnt_d    = '0;
    err_d    = 1'b0;
    reg_oe_d = '0;
    reg_wr_d = '0;
    launch   = 1'b0;

    case (state_q)
      IDLE:  launch = found;
      DRIVE: begin
        rr_ptr_d = ptr_after(idx_q);
`ifdef TURNAROUND_EN
        state_d  = TURN;
`else
        launch   = found;
        state_d  = IDLE;
`endif
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the strobes for the DRIVE cycle are formed here.
    if (launch) begin
      state_d    = DRIVE;
      idx_d      = win;
      gnt_d[win] = 1'b1;
      err_d      = bad_idx;
      if (!bad_idx && (win_src != win_dst)) begin
        reg_oe_d = reg_onehot(win_src);
        reg_wr_d = reg_onehot(win_dst);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      reg_oe_q <= '0;
      reg_wr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      reg_oe_q <= reg_oe_d;
      reg_wr_q <= reg_wr_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.reg_oe = reg_oe_q;
  assign bus.reg_wr = reg_wr_q;

endmodule
